// File: rtl/status_fifo.sv
// Single-clock status FIFO with occupancy flags and programmable almost thresholds.
// Define STATUS_FIFO_STICKY_ERR_EN for sticky overflow/underflow, which adds the err_clr input.
module status_fifo #(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 3,
  parameter int AF_DEFAULT = 6,
  parameter int AE_DEFAULT = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enb,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  input  logic                  th_load,
  input  logic [ADDR_WIDTH:0]   af_th,
  input  logic [ADDR_WIDTH:0]   ae_th,
`ifdef STATUS_FIFO_STICKY_ERR_EN
  input  logic                  err_clr,
`endif
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  almost_full,
  output logic                  empty,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(2 ** ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0]         af_reg, ae_reg;
  logic                  pop_ok, push_ok, ovf_now, udf_now;

  assign full         = (count == DEPTH_C);
  assign empty        = (count == '0);
  assign almost_full  = (count >= af_reg);
  assign almost_empty = (count <= ae_reg);

  // A pop frees a slot on the same edge, so a full FIFO may still accept a push alongside it.
  assign pop_ok  = enb & rd_en & ~empty;
  assign push_ok = enb & wr_en & (~full | pop_ok);
  assign ovf_now = enb & wr_en & full & ~pop_ok;
  assign udf_now = enb & rd_en & empty;

  always_ff @(posedge clk) begin
    if (rst && push_ok) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      af_reg    <= CW'(AF_DEFAULT);
      ae_reg    <= CW'(AE_DEFAULT);
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok) begin
        rd_ptr   <= rd_ptr + 1'b1;
        data_out <= mem[rd_ptr];
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (enb && th_load) begin
        af_reg <= af_th;
        ae_reg <= ae_th;
      end
      valid_out <= pop_ok;
`ifdef STATUS_FIFO_STICKY_ERR_EN
      // A fresh error outranks a clear in the same cycle.
      overflow  <= ovf_now | (overflow & ~err_clr);
      underflow <= udf_now | (underflow & ~err_clr);
`else
      overflow  <= ovf_now;
      underflow <= udf_now;
`endif
    end
  end

endmodule

// File: tb/tb_status_fifo.sv
// Directed bench for status_fifo: a scoreboard queue of expected popped words checked by a
// monitor on valid_out, plus direct flag/count checks from the stimulus thread.
module tb_status_fifo;
  localparam int DW = 6;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          enb = 1'b0;
  logic          wr_en = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          rd_en = 1'b0;
  logic [DW-1:0] data_out;
  logic          valid_out;
  logic          th_load = 1'b0;
  logic [AW:0]   af_th = '0;
  logic [AW:0]   ae_th = '0;
  logic [AW:0]   count;
  logic          full, almost_full, empty, almost_empty, overflow, underflow;
`ifdef STATUS_FIFO_STICKY_ERR_EN
  logic          err_clr = 1'b0;
`endif

  int n_cmp = 0;
  int n_err = 0;
  bit mon_on = 1'b0;
  int exp_q[$];

  status_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_DEFAULT(6), .AE_DEFAULT(2)) dut (
    .clk(clk), .rst(rst), .enb(enb), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .data_out(data_out), .valid_out(valid_out), .th_load(th_load), .af_th(af_th), .ae_th(ae_th),
`ifdef STATUS_FIFO_STICKY_ERR_EN
    .err_clr(err_clr),
`endif
    .count(count), .full(full), .almost_full(almost_full), .empty(empty),
    .almost_empty(almost_empty), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_flags(input string tag, input int c, input int e, input int ae,
                           input int af, input int f);
    chk({tag, " count"}, int'(count), c);
    chk({tag, " empty"}, int'(empty), e);
    chk({tag, " almost_empty"}, int'(almost_empty), ae);
    chk({tag, " almost_full"}, int'(almost_full), af);
    chk({tag, " full"}, int'(full), f);
  endtask

  // Monitor: every word the DUT presents must be the oldest outstanding expectation.
  always @(negedge clk) begin
    if (mon_on && rst && valid_out) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected valid_out: data_out %0d with nothing expected", data_out);
      end else begin
        chk("data_out", int'(data_out), exp_q.pop_front());
      end
    end
  end

  initial begin
    // Reset held for two edges.
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
    enb = 1'b1;
    mon_on = 1'b1;
    chk_flags("reset", 0, 1, 1, 0, 0);
    chk("reset valid_out", int'(valid_out), 0);
    chk("reset overflow", int'(overflow), 0);
    chk("reset underflow", int'(underflow), 0);

    // Fill 1..8: almost_empty while count<=2, almost_full from 6, full at 8.
    for (int i = 1; i <= 8; i++) begin
      wr_en = 1'b1;
      data_in = DW'(i);
      step();
      chk_flags($sformatf("fill%0d", i), i, 0, (i <= 2) ? 1 : 0, (i >= 6) ? 1 : 0,
                (i == 8) ? 1 : 0);
    end
    data_in = DW'(9);
    step();
    chk("overflow pulse", int'(overflow), 1);
    chk("overflow count", int'(count), 8);
    wr_en = 1'b0;
    step();
    chk("overflow drop", int'(overflow), 0);

    // Drain: words 1..8 appear one cycle after each pop.
    for (int i = 1; i <= 8; i++) begin
      rd_en = 1'b1;
      exp_q.push_back(i);
      step();
      chk($sformatf("drain%0d count", i), int'(count), 8 - i);
      chk($sformatf("drain%0d valid", i), int'(valid_out), 1);
    end
    chk_flags("drained", 0, 1, 1, 0, 0);
    step();
    chk("underflow pulse", int'(underflow), 1);
    chk("underflow valid", int'(valid_out), 0);
    rd_en = 1'b0;
    step();
    chk("underflow drop", int'(underflow), 0);

    // Simultaneous push/pop while full: both accepted.
    for (int i = 10; i <= 17; i++) begin
      wr_en = 1'b1;
      data_in = DW'(i);
      step();
    end
    chk("refill full", int'(full), 1);
    data_in = DW'(18);
    rd_en = 1'b1;
    exp_q.push_back(10);
    step();
    chk_flags("full push+pop", 8, 0, 0, 1, 1);
    chk("full push+pop overflow", int'(overflow), 0);
    wr_en = 1'b0;
    for (int i = 11; i <= 18; i++) begin
      exp_q.push_back(i);
      step();
    end
    rd_en = 1'b0;
    step();
    chk("drain2 empty", int'(empty), 1);

    // Simultaneous push/pop while empty: push only, underflow flagged.
    wr_en = 1'b1;
    rd_en = 1'b1;
    data_in = DW'(20);
    step();
    chk("empty push+pop count", int'(count), 1);
    chk("empty push+pop underflow", int'(underflow), 1);
    chk("empty push+pop valid", int'(valid_out), 0);
    wr_en = 1'b0;
    exp_q.push_back(20);
    step();
    rd_en = 1'b0;
    chk("single pop count", int'(count), 0);

    // Freeze at count 4, then reset mid-operation.
    wr_en = 1'b1;
    for (int i = 21; i <= 24; i++) begin
      data_in = DW'(i);
      step();
    end
    chk_flags("pre-freeze", 4, 0, 0, 0, 0);
    enb = 1'b0;
    rd_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk_flags($sformatf("freeze%0d", k), 4, 0, 0, 0, 0);
      chk($sformatf("freeze%0d valid", k), int'(valid_out), 0);
    end
    enb = 1'b1;
    rd_en = 1'b0;
    rst = 1'b0;
    step();
    rst = 1'b1;
    wr_en = 1'b0;
    chk_flags("mid reset", 0, 1, 1, 0, 0);

    // Threshold load at count 2.
    wr_en = 1'b1;
    for (int i = 30; i <= 31; i++) begin
      data_in = DW'(i);
      step();
    end
    wr_en = 1'b0;
    chk_flags("pre-load", 2, 0, 1, 0, 0);
    th_load = 1'b1;
    af_th = 4'd2;
    ae_th = 4'd0;
    step();
    chk("load af=2", int'(almost_full), 1);
    chk("load ae=0", int'(almost_empty), 0);
    af_th = 4'd9;
    ae_th = 4'd8;
    step();
    th_load = 1'b0;
    chk("load af=9", int'(almost_full), 0);
    chk("load ae=8", int'(almost_empty), 1);

    // Overflow after filling; sticky behaviour depends on build.
    wr_en = 1'b1;
    for (int i = 32; i <= 37; i++) begin
      data_in = DW'(i);
      step();
    end
    chk("refill3 full", int'(full), 1);
    chk("af=9 at full", int'(almost_full), 0);
    data_in = DW'(40);
    step();
    chk("overflow3", int'(overflow), 1);
    wr_en = 1'b0;
    step();
`ifdef STATUS_FIFO_STICKY_ERR_EN
    chk("sticky overflow hold", int'(overflow), 1);
    enb = 1'b0;
    step();
    chk("sticky overflow enb0", int'(overflow), 1);
    enb = 1'b1;
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("sticky overflow cleared", int'(overflow), 0);
`else
    chk("pulse overflow drop", int'(overflow), 0);
`endif

    rd_en = 1'b1;
    for (int i = 30; i <= 37; i++) begin
      exp_q.push_back(i);
      step();
    end
    rd_en = 1'b0;
    step();
    step();
    chk("final empty", int'(empty), 1);
    chk("scoreboard leftover", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
